// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the core datapath (master) and pipe_hazard_ctrl (slave).
// Carries per-stage stall sources, cache stalls, flush request and the resulting controls.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int CNT_W   = 32
);
  logic [NSTAGES-1:0] stall_req;
  logic               i_stall;
  logic               d_stall;
  logic               flush_req;
  logic [NSTAGES-1:0] stall;
  logic [NSTAGES-1:0] flush;
  logic [NSTAGES-1:0] valid;
  logic               i_longest_stall;
  logic               d_longest_stall;
  logic               flush_pending;
  logic [CNT_W-1:0]   perf_stall_i;
  logic [CNT_W-1:0]   perf_stall_d;
  logic [CNT_W-1:0]   perf_flush;

  modport master (
    output stall_req, i_stall, d_stall, flush_req,
    input  stall, flush, valid, i_longest_stall, d_longest_stall, flush_pending,
           perf_stall_i, perf_stall_d, perf_flush
  );

  modport slave (
    input  stall_req, i_stall, d_stall, flush_req,
    output stall, flush, valid, i_longest_stall, d_longest_stall, flush_pending,
           perf_stall_i, perf_stall_d, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/valid controller for the pipelined core; exception flushes wait out D-side stalls.
// Optional performance counters are built only when STALL_PERF_EN is defined.

// Per-stage valid bit: flush beats stall beats advance.
module pipe_hazard_stage (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic stall,
  input  logic prevValid,
  output logic valid
);
  always_ff @(posedge clk) begin
    if (!rst)       valid <= 1'b0;
    else if (flush) valid <= 1'b0;
    else if (!stall) valid <= prevValid;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int NSTAGES   = 5,
  parameter int MEM_STAGE = 3,
  parameter int EXC_STAGE = 3,
  parameter int CNT_W     = 32
) (
  input logic             clk,
  input logic             rst,
  pipe_hazard_ctrl_if.slave hz
);
  logic [NSTAGES-1:0] src, stallBase, flushBase, stallOut, flushOut, vldPipe;
  logic               flushPending, apply, freeze;

  always_comb begin
    src = hz.stall_req;
    src[0]         = src[0] | hz.i_stall;
    src[MEM_STAGE] = src[MEM_STAGE] | hz.d_stall;
  end

  // A stalled stage forces every stage behind it to stall too.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stallBase = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      acc          = acc | src[k];
      stallBase[k] = acc;
    end
  end

  always_comb begin
    flushBase = '0;
    for (int k = 1; k < NSTAGES; k++)
      flushBase[k] = stallBase[k-1] & ~stallBase[k];
  end

  // A flush cannot squash the stage while its D-access is still outstanding.
  assign apply = (hz.flush_req | flushPending) & ~hz.d_stall;

  always_comb begin
    stallOut = stallBase;
    flushOut = flushBase;
    for (int k = 0; k <= EXC_STAGE; k++) begin
      if (apply) begin
        stallOut[k] = 1'b0;
        flushOut[k] = 1'b1;
      end
    end
  end

  assign freeze = (|src[NSTAGES-1:MEM_STAGE]) | hz.d_stall;

  always_ff @(posedge clk) begin
    if (!rst)                          flushPending <= 1'b0;
    else if (hz.flush_req && hz.d_stall) flushPending <= 1'b1;
    else if (apply)                    flushPending <= 1'b0;
  end

  // The PC stage always holds a real fetch slot.
  always_ff @(posedge clk) vldPipe[0] <= 1'b1;

  for (genvar k = 1; k < NSTAGES; k++) begin : gStage
    pipe_hazard_stage uStage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flushOut[k]),
      .stall    (stallOut[k]),
      .prevValid(vldPipe[k-1]),
      .valid    (vldPipe[k])
    );
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] cntI, cntD, cntF;
  always_ff @(posedge clk) begin
    if (!rst) begin
      cntI <= '0;
      cntD <= '0;
      cntF <= '0;
    end else begin
      if (hz.i_stall) cntI <= cntI + 1'b1;
      if (hz.d_stall) cntD <= cntD + 1'b1;
      if (apply)      cntF <= cntF + 1'b1;
    end
  end
  assign hz.perf_stall_i = cntI;
  assign hz.perf_stall_d = cntD;
  assign hz.perf_flush   = cntF;
`else
  assign hz.perf_stall_i = '0;
  assign hz.perf_stall_d = '0;
  assign hz.perf_flush   = '0;
`endif

  assign hz.stall           = stallOut;
  assign hz.flush           = flushOut;
  assign hz.valid           = vldPipe;
  assign hz.i_longest_stall = stallOut[0] | freeze;
  assign hz.d_longest_stall = freeze;
  assign hz.flush_pending   = flushPending;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against a stall-front reference model.
module tb_pipe_hazard_ctrl;
  localparam int N   = 5;
  localparam int MEM = 3;
  localparam int EXC = 3;
  localparam int CW  = 32;
`ifdef STALL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NSTAGES(N), .CNT_W(CW)) hz ();

  pipe_hazard_ctrl #(.NSTAGES(N), .MEM_STAGE(MEM), .EXC_STAGE(EXC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hz(hz)
  );

  int vecs = 0;
  int errs = 0;

  logic [N-1:0]  expStall, expFlush, mValid;
  logic          expIl, expDl, mPend, mApply;
  logic [CW-1:0] mPi, mPd, mPf;

  // Model: everything at or below the highest stall source stalls; a bubble
  // appears just above it; an applied flush wipes stages 0..EXC.
  task automatic modelComb();
    logic [N-1:0] s;
    int h;
    s = hz.stall_req;
    if (hz.i_stall) s[0] = 1'b1;
    if (hz.d_stall) s[MEM] = 1'b1;
    h = -1;
    for (int k = 0; k < N; k++) if (s[k]) h = k;
    expStall = (h >= 0) ? N'((1 << (h + 1)) - 1) : '0;
    expFlush = (h >= 0 && h + 1 < N) ? N'(1 << (h + 1)) : '0;
    mApply = (hz.flush_req | mPend) & ~hz.d_stall;
    if (mApply) begin
      expStall = expStall & ~N'((1 << (EXC + 1)) - 1);
      expFlush = expFlush | N'((1 << (EXC + 1)) - 1);
    end
    expDl = (h >= MEM) || hz.d_stall;
    expIl = expStall[0] | expDl;
  endtask

  task automatic modelSeq();
    logic [N-1:0] nv;
    if (!rst) begin
      mValid = N'(1); mPend = 1'b0; mPi = '0; mPd = '0; mPf = '0;
    end else begin
      nv[0] = 1'b1;
      for (int k = 1; k < N; k++)
        nv[k] = expFlush[k] ? 1'b0 : (expStall[k] ? mValid[k] : mValid[k-1]);
      if (PERF) begin
        if (hz.i_stall) mPi = mPi + 1;
        if (hz.d_stall) mPd = mPd + 1;
        if (mApply)     mPf = mPf + 1;
      end
      if (hz.flush_req && hz.d_stall) mPend = 1'b1;
      else if (mApply)                mPend = 1'b0;
      mValid = nv;
    end
  endtask

  task automatic drive(input logic [N-1:0] sr, input logic is, input logic ds,
                       input logic fr, input logic r);
    @(negedge clk);
    hz.stall_req = sr; hz.i_stall = is; hz.d_stall = ds; hz.flush_req = fr; rst = r;
    #1 modelComb();
  endtask

  task automatic tick();
    @(posedge clk);
    modelSeq();
    #1;
  endtask

  task automatic test_reset();
    drive(N'($urandom), 1'b1, 1'b1, 1'b1, 1'b0); tick();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs++; if (hz.valid !== 5'b00001) begin errs++; $display("FAIL reset_valid got %b want 00001", hz.valid); end
    vecs++; if (hz.flush_pending !== 1'b0) begin errs++; $display("FAIL reset_pending got %b want 0", hz.flush_pending); end
    vecs++; if ({hz.perf_stall_i, hz.perf_stall_d, hz.perf_flush} !== '0) begin
      errs++; $display("FAIL reset_perf got %0d/%0d/%0d want 0", hz.perf_stall_i, hz.perf_stall_d, hz.perf_flush); end
    vecs++; if (hz.flush !== 5'b00000) begin errs++; $display("FAIL reset_flush got %b want 00000", hz.flush); end
    tick();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 5; i++) begin drive('0, 1'b0, 1'b0, 1'b0, 1'b1); tick(); end
    vecs++; if (hz.valid !== 5'b11111) begin errs++; $display("FAIL fill_valid got %b want 11111", hz.valid); end
    drive(5'b00010, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs++; if (hz.stall !== 5'b00011) begin errs++; $display("FAIL loaduse_stall got %b want 00011", hz.stall); end
    vecs++; if (hz.flush !== 5'b00100) begin errs++; $display("FAIL loaduse_flush got %b want 00100", hz.flush); end
    vecs++; if (hz.i_longest_stall !== 1'b1 || hz.d_longest_stall !== 1'b0) begin
      errs++; $display("FAIL loaduse_hold got %b%b want 10", hz.i_longest_stall, hz.d_longest_stall); end
    tick();
    vecs++; if (hz.valid !== 5'b11011) begin errs++; $display("FAIL loaduse_valid got %b want 11011", hz.valid); end
  endtask

  task automatic test_dcache_miss();
    logic [CW-1:0] base;
    base = hz.perf_stall_d;
    for (int i = 0; i < 3; i++) begin
      drive('0, 1'b0, 1'b1, 1'b0, 1'b1);
      vecs++; if (hz.stall !== 5'b01111 || hz.flush !== 5'b10000) begin
        errs++; $display("FAIL dmiss_ctrl got stall=%b flush=%b want 01111/10000", hz.stall, hz.flush); end
      vecs++; if (hz.i_longest_stall !== 1'b1 || hz.d_longest_stall !== 1'b1) begin
        errs++; $display("FAIL dmiss_hold got %b%b want 11", hz.i_longest_stall, hz.d_longest_stall); end
      tick();
    end
    vecs++; if (hz.perf_stall_d - base !== (PERF ? CW'(3) : CW'(0))) begin
      errs++; $display("FAIL dmiss_perf got delta %0d want %0d", hz.perf_stall_d - base, PERF ? 3 : 0); end
  endtask

  task automatic test_deferred_flush();
    logic [CW-1:0] base;
    base = hz.perf_flush;
    drive('0, 1'b0, 1'b1, 1'b1, 1'b1);
    vecs++; if (hz.flush !== 5'b10000) begin errs++; $display("FAIL defer_noflush got %b want 10000", hz.flush); end
    tick();
    vecs++; if (hz.flush_pending !== 1'b1) begin errs++; $display("FAIL defer_pending got %b want 1", hz.flush_pending); end
    drive('0, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs++; if (hz.flush !== 5'b10000) begin errs++; $display("FAIL defer_wait got %b want 10000", hz.flush); end
    tick();
    drive('0, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs++; if (hz.flush[3:0] !== 4'b1111 || hz.stall !== 5'b00000) begin
      errs++; $display("FAIL defer_apply got flush=%b stall=%b want x1111/00000", hz.flush, hz.stall); end
    tick();
    vecs++; if (hz.flush_pending !== 1'b0) begin errs++; $display("FAIL defer_clear got %b want 0", hz.flush_pending); end
    vecs++; if (hz.perf_flush - base !== (PERF ? CW'(1) : CW'(0))) begin
      errs++; $display("FAIL defer_perf got delta %0d want %0d", hz.perf_flush - base, PERF ? 1 : 0); end
  endtask

  task automatic test_simultaneous();
    drive(5'b00010, 1'b1, 1'b0, 1'b1, 1'b1);
    vecs++; if (hz.flush[3:0] !== 4'b1111 || hz.stall[3:0] !== 4'b0000) begin
      errs++; $display("FAIL simul got flush=%b stall=%b want x1111/x0000", hz.flush, hz.stall); end
    tick();
    vecs++; if (hz.valid !== mValid) begin errs++; $display("FAIL simul_valid got %b want %b", hz.valid, mValid); end
  endtask

  task automatic test_reset_mid_stall();
    drive('0, 1'b0, 1'b1, 1'b1, 1'b1); tick();
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    vecs++; if (hz.flush_pending !== 1'b0 || hz.flush !== 5'b00000) begin
      errs++; $display("FAIL rstmid got pending=%b flush=%b want 0/00000", hz.flush_pending, hz.flush); end
    vecs++; if (hz.valid !== 5'b00001 || hz.perf_stall_d !== '0) begin
      errs++; $display("FAIL rstmid_state got valid=%b perf_d=%0d want 00001/0", hz.valid, hz.perf_stall_d); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom & $urandom & $urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 60) != 0);
      vecs++; if (hz.stall !== expStall || hz.flush !== expFlush) begin
        errs++; $display("FAIL rnd_ctrl cyc%0d got %b/%b want %b/%b", i, hz.stall, hz.flush, expStall, expFlush); end
      vecs++; if (hz.i_longest_stall !== expIl || hz.d_longest_stall !== expDl) begin
        errs++; $display("FAIL rnd_hold cyc%0d got %b%b want %b%b", i, hz.i_longest_stall, hz.d_longest_stall, expIl, expDl); end
      tick();
      vecs++; if (hz.valid !== mValid || hz.flush_pending !== mPend) begin
        errs++; $display("FAIL rnd_state cyc%0d got %b/%b want %b/%b", i, hz.valid, hz.flush_pending, mValid, mPend); end
      vecs++; if (hz.perf_stall_i !== mPi || hz.perf_stall_d !== mPd || hz.perf_flush !== mPf) begin
        errs++; $display("FAIL rnd_perf cyc%0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         hz.perf_stall_i, hz.perf_stall_d, hz.perf_flush, mPi, mPd, mPf); end
    end
  endtask

  initial begin
    hz.stall_req = '0; hz.i_stall = 1'b0; hz.d_stall = 1'b0; hz.flush_req = 1'b0;
    mValid = '0; mPend = 1'b0; mPi = '0; mPd = '0; mPf = '0;
    test_reset();
    test_load_use();
    test_dcache_miss();
    test_deferred_flush();
    test_simultaneous();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
